// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
// Branch types, multiply FSM states and the hard-wired zero register.
package pipe_ctrl_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_MULT_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for stall/flush performance debug.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: taken branches,
// multi-cycle multiply occupancy of EX and load-use hazards.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [4:0]           IFIDRsIn,
  input  logic [4:0]           IFIDRtIn,
  input  logic                 IFIDUsesRtIn,
  input  logic                 IDEXMemReadIn,
  input  logic [4:0]           IDEXRtIn,
  input  logic                 IDEXMultStartIn,
  input  logic [1:0]           EXMEMBranchIn,
  input  logic                 EXMEMZeroIn,
  output logic                 PCWriteOut,
  output logic                 IFIDWriteOut,
  output logic                 IFIDFlushOut,
  output logic                 IDEXWriteOut,
  output logic                 IDEXFlushOut,
  output logic                 EXMEMFlushOut,
  output logic                 PCSrcOut,
  output logic                 MultBusyOut,
  output logic [CNT_WIDTH-1:0] StallCountOut,
  output logic [CNT_WIDTH-1:0] FlushCountOut
);

  localparam int MW = $clog2(MULT_LATENCY);

  state_e        state_q, state_d;
  logic [MW-1:0] mcnt_q, mcnt_d;

  logic taken;
  logic mult_stall;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  always_comb begin
    taken = ((EXMEMBranchIn == BR_BEQ) && EXMEMZeroIn)
         || ((EXMEMBranchIn == BR_BNE) && !EXMEMZeroIn)
         ||  (EXMEMBranchIn == BR_JUMP);
    mult_stall = ((state_q == ST_RUN) && IDEXMultStartIn)
              || ((state_q == ST_MULT_BUSY) && (mcnt_q != '0));
    load_use = IDEXMemReadIn && (IDEXRtIn != REG_ZERO)
            && ((IDEXRtIn == IFIDRsIn)
             || (IFIDUsesRtIn && (IDEXRtIn == IFIDRtIn)));
  end

  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    PCWriteOut    = 1'b1;
    IFIDWriteOut  = 1'b1;
    IFIDFlushOut  = 1'b0;
    IDEXWriteOut  = 1'b1;
    IDEXFlushOut  = 1'b0;
    EXMEMFlushOut = 1'b0;
    PCSrcOut      = 1'b0;
    MultBusyOut   = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (Reset) begin
      PCWriteOut    = 1'b0;
      IFIDWriteOut  = 1'b0;
      IDEXWriteOut  = 1'b0;
      IFIDFlushOut  = 1'b1;
      IDEXFlushOut  = 1'b1;
      EXMEMFlushOut = 1'b1;
      state_d       = ST_RUN;
      mcnt_d        = '0;
    end else if (taken) begin
      // Squashes any multiply in flight along with the wrong-path work.
      PCSrcOut      = 1'b1;
      IFIDFlushOut  = 1'b1;
      IDEXFlushOut  = 1'b1;
      EXMEMFlushOut = 1'b1;
      state_d       = ST_RUN;
      mcnt_d        = '0;
      flush_inc     = 1'b1;
    end else if (mult_stall) begin
      PCWriteOut    = 1'b0;
      IFIDWriteOut  = 1'b0;
      IDEXWriteOut  = 1'b0;
      EXMEMFlushOut = 1'b1;
      MultBusyOut   = 1'b1;
      stall_inc     = 1'b1;
      if (state_q == ST_RUN) begin
        state_d = ST_MULT_BUSY;
        mcnt_d  = MW'(MULT_LATENCY - 2);
      end else begin
        mcnt_d = mcnt_q - MW'(1);
      end
    end else begin
      if (state_q == ST_MULT_BUSY) begin
        state_d = ST_RUN;
      end
      if (load_use) begin
        PCWriteOut   = 1'b0;
        IFIDWriteOut = 1'b0;
        IDEXFlushOut = 1'b1;
        stall_inc    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    mcnt_q  <= mcnt_d;
  end

  hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .Reset (Reset),
    .inc   (stall_inc),
    .count (StallCountOut)
  );

  hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .Reset (Reset),
    .inc   (flush_inc),
    .count (FlushCountOut)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard queue.
// Control vector: {PCW, IFIDW, IFIDF, IDEXW, IDEXF, EXMEMF, PCSrc, Busy}.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [7:0] E_RUN = 8'b1101_0000;
  localparam logic [7:0] E_LU  = 8'b0001_1000;
  localparam logic [7:0] E_MUL = 8'b0000_0101;
  localparam logic [7:0] E_BR  = 8'b1111_1110;
  localparam logic [7:0] E_RST = 8'b0010_1100;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memrd;
    logic [4:0] idex_rt;
    logic       mstart;
    logic [1:0] br;
    logic       zero;
  } in_t;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
    logic          chk_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  in_t  in;

  logic          pcw, ifidw, ifidf, idexw, idexf, exmemf, pcsrc, busy;
  logic [CW-1:0] scnt_o, fcnt_o;
  logic [7:0]    ctrl_o;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            stepn  = 0;
  logic [CW-1:0] scnt_m = '0;
  logic [CW-1:0] fcnt_m = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULT_LATENCY(4), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .Reset           (rst),
    .IFIDRsIn        (in.rs),
    .IFIDRtIn        (in.rt),
    .IFIDUsesRtIn    (in.uses_rt),
    .IDEXMemReadIn   (in.memrd),
    .IDEXRtIn        (in.idex_rt),
    .IDEXMultStartIn (in.mstart),
    .EXMEMBranchIn   (in.br),
    .EXMEMZeroIn     (in.zero),
    .PCWriteOut      (pcw),
    .IFIDWriteOut    (ifidw),
    .IFIDFlushOut    (ifidf),
    .IDEXWriteOut    (idexw),
    .IDEXFlushOut    (idexf),
    .EXMEMFlushOut   (exmemf),
    .PCSrcOut        (pcsrc),
    .MultBusyOut     (busy),
    .StallCountOut   (scnt_o),
    .FlushCountOut   (fcnt_o)
  );

  assign ctrl_o = {pcw, ifidw, ifidf, idexw, idexf, exmemf, pcsrc, busy};

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic ur, input logic mr,
                             input logic [4:0] xrt, input logic ms,
                             input logic [1:0] br, input logic z);
    in_t t;
    t.rs = rs; t.rt = rt; t.uses_rt = ur; t.memrd = mr;
    t.idex_rt = xrt; t.mstart = ms; t.br = br; t.zero = z;
    return t;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic r, input in_t i, input logic [7:0] e,
                      input bit chk);
    exp_t x;
    exp_t got;
    rst = r;
    in  = i;
    x.ctrl = e; x.scnt = scnt_m; x.fcnt = fcnt_m; x.chk_cnt = chk;
    sb.push_back(x);
    @(negedge clk);
    stepn++;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty step %0d observed=0 expected=1", stepn);
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      checks++;
      assert (ctrl_o === got.ctrl) else begin
        errors++;
        $error("FAIL ctrl step %0d observed=%b expected=%b",
               stepn, ctrl_o, got.ctrl);
      end
      if (got.chk_cnt) begin
        checks += 2;
        assert (scnt_o === got.scnt) else begin
          errors++;
          $error("FAIL stall_cnt step %0d observed=%0d expected=%0d",
                 stepn, scnt_o, got.scnt);
        end
        assert (fcnt_o === got.fcnt) else begin
          errors++;
          $error("FAIL flush_cnt step %0d observed=%0d expected=%0d",
                 stepn, fcnt_o, got.fcnt);
        end
      end
    end
    @(posedge clk);
    if (r) begin
      scnt_m = '0;
      fcnt_m = '0;
    end else begin
      if (e == E_LU || e == E_MUL) scnt_m = sat_inc(scnt_m);
      if (e == E_BR) fcnt_m = sat_inc(fcnt_m);
    end
    #1;
  endtask

  in_t idle, lu_rs, lu_rt, mul;

  initial begin
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    lu_rs = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    lu_rt = mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 2'b00, 1'b0);
    mul   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b00, 1'b0);
    rst = 1'b1;
    in  = idle;
    @(posedge clk);
    #1;

    // reset with random inputs; counters defined after first edge
    for (int k = 0; k < 3; k++) begin
      step(1'b1, in_t'($urandom), E_RST, k > 0);
    end
    step(1'b0, idle, E_RUN, 1'b1);

    // load-use
    step(1'b0, lu_rs, E_LU, 1'b1);
    step(1'b0, idle, E_RUN, 1'b1);
    step(1'b0, mk(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 2'b00, 1'b0),
         E_RUN, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0),
         E_RUN, 1'b1);
    step(1'b0, lu_rt, E_LU, 1'b1);
    step(1'b0, idle, E_RUN, 1'b1);

    // branches
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 1'b1),
         E_BR, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b1),
         E_RUN, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b11, 1'b0),
         E_BR, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 1'b0),
         E_RUN, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0),
         E_BR, 1'b1);
    // branch beats load-use, no stall counted
    step(1'b0, mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 2'b11, 1'b1),
         E_BR, 1'b1);

    // two back-to-back multiplies, each 3 stall cycles
    for (int m = 0; m < 2; m++) begin
      step(1'b0, mul, E_MUL, 1'b1);
      step(1'b0, mul, E_MUL, 1'b1);
      step(1'b0, mul, E_MUL, 1'b1);
      step(1'b0, mul, E_RUN, 1'b1);
    end
    step(1'b0, idle, E_RUN, 1'b1);

    // branch squashes a multiply in MULT_BUSY
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b11, 1'b0),
         E_BR, 1'b1);
    step(1'b0, idle, E_RUN, 1'b1);

    // reset mid-multiply restarts full latency
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b1, mul, E_RST, 1'b1);
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mul, E_MUL, 1'b1);
    step(1'b0, mul, E_RUN, 1'b1);
    step(1'b0, idle, E_RUN, 1'b1);

    // saturation of the stall counter
    for (int s = 0; s < 20; s++) begin
      step(1'b0, lu_rs, E_LU, 1'b1);
    end
    step(1'b0, idle, E_RUN, 1'b1);
    checks++;
    assert (scnt_o === 4'd15) else begin
      errors++;
      $error("FAIL stall_sat observed=%0d expected=15", scnt_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline.
- Sequences the PC, IF/ID, ID/EX and EX/MEM pipeline registers by driving their write-enable and flush (bubble) controls.
- Detects three conditions: load-use hazards, branches resolved in MEM, and multi-cycle multiply occupancy of EX.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
MULT_LATENCY, 4, total cycles a multiply occupies EX (legal range >= 2)
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
IFIDRsIn  input  5  rs field of the instruction in IF/ID
IFIDRtIn  input  5  rt field of the instruction in IF/ID
IFIDUsesRtIn  input  1  IF/ID instruction reads rt as a source
IDEXMemReadIn  input  1  ID/EX instruction is a load
IDEXRtIn  input  5  load destination register in ID/EX
IDEXMultStartIn  input  1  ID/EX instruction is a multi-cycle multiply
EXMEMBranchIn  input  2  branch type in EX/MEM: 00 none, 01 beq, 10 bne, 11 jump
EXMEMZeroIn  input  1  ALU zero flag in EX/MEM
PCWriteOut  output  1  PC load enable
IFIDWriteOut  output  1  IF/ID load enable
IFIDFlushOut  output  1  IF/ID load of NOP
IDEXWriteOut  output  1  ID/EX load enable
IDEXFlushOut  output  1  ID/EX load of bubble (all control bits 0)
EXMEMFlushOut  output  1  EX/MEM load of bubble
PCSrcOut  output  1  1 selects EX/MEM branch target for the PC
MultBusyOut  output  1  multiply is holding EX this cycle
StallCountOut  output  CNT_WIDTH  saturating count of stall cycles
FlushCountOut  output  CNT_WIDTH  saturating count of taken branches

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All registered state updates on the rising edge of clk.
- Control outputs are combinational from registered state and the current inputs, so a stall takes effect in the same cycle the hazard is seen.
- Reset asserted:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, all three flushes=1, PCSrc=0, MultBusy=0.
  - State: state<=RUN, mcnt<=0, both counters<=0.
- Default (no hazard): all write enables =1, all flushes =0, PCSrc=0.
- Taken branch (highest priority): BranchIn=01 & Zero, or BranchIn=10 & !Zero, or BranchIn=11.
  - Outputs: PCSrc=1, PCWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1.
  - State: state<=RUN, mcnt<=0, which aborts any multiply in progress.
  - FlushCount += 1.
- Multiply FSM, states RUN and MULT_BUSY, down-counter mcnt of width clog2(MULT_LATENCY):
  - RUN & MultStart & no taken branch: stall, state<=MULT_BUSY, mcnt<=MULT_LATENCY-2.
  - MULT_BUSY & mcnt!=0: stall, mcnt<=mcnt-1.
  - MULT_BUSY & mcnt==0: no stall, pipeline advances, state<=RUN.
  - Multiply stall outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1, MultBusy=1.
  - Net effect: exactly MULT_LATENCY-1 stall cycles per multiply. Back-to-back multiplies re-trigger from RUN on the next cycle.
- Load-use (lowest priority; only when not taken-branch and not multiply-stalling):
  - Condition: IDEXMemRead & IDEXRt!=0 & (IDEXRt==IFIDRs | (IFIDUsesRt & IDEXRt==IFIDRt)).
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IDEXWrite=1.
  - Resolves itself after one cycle because the bubble clears IDEXMemRead.
- StallCount += 1 on every non-reset cycle with a multiply or load-use stall.
- Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - Branch + multiply: the branch wins and the multiply is squashed.
  - Branch + load-use: the branch wins and no stall is counted.
  - Multiply + load-use in the same cycle cannot occur legitimately; if it does, multiply handling wins.
- Reset mid-multiply: FSM returns to RUN immediately and the next multiply restarts the full latency.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - branch encodings BR_NONE=2'b00, BR_BEQ=2'b01, BR_BNE=2'b10, BR_JUMP=2'b11;
  - FSM state encodings ST_RUN, ST_MULT_BUSY;
  - REG_ZERO=5'd0.
- One sub-module, hazard_sat_counter (parameter WIDTH; inputs clk, Reset, inc; output count), instantiated twice for the stall and flush counters.

Test Plan:
1. Reset held 3 cycles with random inputs -> PCWrite=0, all flushes=1, counters=0; first cycle after release with idle inputs -> all writes=1, flushes=0.
2. IDEXMemRead=1, IDEXRt=5, IFIDRs=5 -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount=1. Repeat with IFIDRt=5, IFIDUsesRt=0 -> no stall. Repeat with IDEXRt=0 -> no stall.
3. BranchIn=01, Zero=1 -> PCSrc=1, all three flushes=1, FlushCount=1. BranchIn=10, Zero=1 -> not taken. BranchIn=11 -> taken regardless of Zero.
4. MULT_LATENCY=4, MultStart pulsed for one instruction -> MultBusy high 3 consecutive cycles, PC held, EXMEMFlush=1 each cycle; advance on the 4th cycle; StallCount=3.
5. Multiply started, then BranchIn=11 on the 2nd busy cycle -> flush in that cycle, FSM back to RUN, MultBusy=0 the next cycle, StallCount=2, FlushCount=1.
6. CNT_WIDTH=4, 20 consecutive load-use stalls -> StallCountOut holds at 15 and does not wrap.
